// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM states,
// default oversampling ratio and the frame-format control encodings.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic D_NUM_7     = 1'b0;
  localparam logic D_NUM_8     = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line, frame format,
// received byte and status flags.
interface uart_rx_if;
  logic       rx;
  logic       d_num;
  logic       parity;
  logic       stop_bits;
  logic       rd_ack;
  logic [7:0] data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport slave (
    input  rx, d_num, parity, stop_bits, rd_ack,
    output data, rx_valid, parity_err, frame_err, overrun, busy
  );

  modport master (
    output rx, d_num, parity, stop_bits, rd_ack,
    input  data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line with a registered
// falling-edge pulse; idles high so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk_rx,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic meta;
  logic rx_q;

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
      fall <= 1'b0;
    end else begin
      meta <= rx;
      rx_s <= meta;
      rx_q <= rx_s;
      fall <= rx_q & ~rx_s;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver on a 16x (OVERSAMPLE) clock: start detect, mid-bit
// sampling, parity/stop checking and a sticky host handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic      clk_rx,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int            CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 2);

  logic          rx_s, fall;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_acc, par_bad, stop_bad;
  logic          fmt_d8, fmt_odd, fmt_two;
  logic          tick, done, busy, last_data, stop_now_bad;
  logic [7:0]    data_q;
  logic          valid_q, perr_q, ferr_q, ovr_q;

  uart_rx_sync u_sync (
    .clk_rx (clk_rx),
    .reset  (reset),
    .rx     (bus.rx),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fall) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && last_data) state_nxt = PARITY;
      PARITY:    if (tick) state_nxt = STOP1;
      STOP1:     if (tick) state_nxt = (fmt_two == STOP_TWO) ? STOP2
                                     : (stop_now_bad ? WAIT_HIGH : IDLE);
      STOP2:     if (tick) state_nxt = stop_now_bad ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // START waits half a bit to land mid-bit; every later bit is a full period on.
  always_comb begin
    busy         = (state != IDLE);
    tick         = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
    last_data    = (idx == ((fmt_d8 == D_NUM_8) ? 3'd7 : 3'd6));
    stop_now_bad = stop_bad | ~rx_s;
    done         = tick && ((state == STOP1 && fmt_two == STOP_ONE) || state == STOP2);
  end

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      fmt_d8   <= 1'b0;
      fmt_odd  <= 1'b0;
      fmt_two  <= 1'b0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + CW'(1);

      if (state == IDLE && fall) begin
        fmt_d8   <= bus.d_num;
        fmt_odd  <= bus.parity;
        fmt_two  <= bus.stop_bits;
        idx      <= '0;
        shreg    <= '0;
        par_acc  <= 1'b0;
        stop_bad <= 1'b0;
      end

      if (tick) begin
        case (state)
          DATA: begin
            shreg   <= {rx_s, shreg[7:1]};
            par_acc <= par_acc ^ rx_s;
            idx     <= idx + 3'd1;
          end
          PARITY:       par_bad  <= rx_s ^ par_acc ^ fmt_odd;
          STOP1, STOP2: stop_bad <= stop_now_bad;
          default: ;
        endcase
      end
    end
  end

  // A completing frame beats a simultaneous acknowledge.
  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done) begin
      data_q  <= (fmt_d8 == D_NUM_8) ? shreg : {1'b0, shreg[7:1]};
      perr_q  <= par_bad;
      ferr_q  <= stop_now_bad;
      valid_q <= 1'b1;
      if (bus.rd_ack)   ovr_q <= 1'b0;
      else if (valid_q) ovr_q <= 1'b1;
    end else if (bus.rd_ack) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign bus.data       = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random formats, checked against
// a frame-level model of the received byte, flags and handshake.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_rx (clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_cyc = -1;
  logic vld_prev = 1'b0;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Latency from line fall to rx_valid: frame time plus 2..3 cycles of sync/edge detect.
  task automatic chk_lat(input string tag, input int lat, input int t);
    n_chk++;
    assert (lat >= t + 2 && lat <= t + 3) else begin
      n_fail++;
      $error("FAIL %s: observed latency %0d expected %0d..%0d", tag, lat, t + 2, t + 3);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!vld_prev && bus.rx_valid === 1'b1) rise_cyc = cyc;
    vld_prev = bus.rx_valid;
  endtask

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) step();
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".data"},  bus.data,       m_data);
    chk({tag, ".valid"}, bus.rx_valid,   m_valid);
    chk({tag, ".perr"},  bus.parity_err, m_perr);
    chk({tag, ".ferr"},  bus.frame_err,  m_ferr);
    chk({tag, ".ovr"},   bus.overrun,    m_ovr);
  endtask

  task automatic ack();
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
    step();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Sends one frame at 16 cycles per bit; returns rx_valid rise latency and
  // the busy level sampled a few cycles after the start edge.
  task automatic send_frame(input logic [7:0] b, input logic d8, input logic odd,
                            input logic two, input logic flip, input logic stop_val,
                            output int lat, output logic busy_mid);
    logic [7:0] d;
    logic       pb;
    int         n, start;
    n  = d8 ? 8 : 7;
    d  = d8 ? b : {1'b0, b[6:0]};
    pb = (^d) ^ odd ^ flip;
    bus.d_num     = d8;
    bus.parity    = odd;
    bus.stop_bits = two;
    rise_cyc = -1;
    start    = cyc;
    hold(1'b0, 6);
    busy_mid = bus.busy;
    hold(1'b0, 10);
    for (int i = 0; i < n; i++) hold(d[i], 16);
    hold(pb, 16);
    hold(stop_val, 16);
    if (two) hold(stop_val, 16);
    lat = (rise_cyc < 0) ? -1 : rise_cyc - start;
    m_perr = (pb != ((^d) ^ odd));
    m_ferr = ~stop_val;
    m_data = d;
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
  endtask

  function automatic int frame_t(input logic d8, input logic two);
    return 8 + 16 * ((d8 ? 8 : 7) + 1 + (two ? 2 : 1));
  endfunction

  initial begin
    int         lat, start;
    logic       bm;
    logic [7:0] b;
    logic       d8, odd, two, flip;

    bus.rx = 1'b1; bus.rd_ack = 1'b0;
    bus.d_num = D_NUM_8; bus.parity = PARITY_EVEN; bus.stop_bits = STOP_ONE;
    reset = 1'b0;
    repeat (3) step();
    check_outs("reset");
    chk("reset.busy", bus.busy, 1'b0);
    reset = 1'b1;
    repeat (4) step();

    // 8E1 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    chk_lat("a5.lat", lat, 168);
    chk("a5.busy_mid", bm, 1'b1);
    check_outs("a5");
    hold(1'b1, 4);
    chk("a5.busy_after", bus.busy, 1'b0);
    ack();
    chk("a5.ack_valid", bus.rx_valid, 1'b0);

    // 7O2 0x55
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lat, bm);
    chk_lat("55.lat", lat, 168);
    check_outs("55");
    hold(1'b1, 4);
    ack();

    // 5-cycle glitch is a false start
    start = cyc;
    hold(1'b0, 5);
    hold(1'b1, 7);
    chk("glitch.busy", bus.busy, 1'b0);
    hold(1'b1, 20);
    check_outs("glitch");
    chk("glitch.norise", (rise_cyc > start), 1'b0);

    // parity error, then clean frame clears it
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, lat, bm);
    check_outs("perr");
    hold(1'b1, 4);
    ack();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    check_outs("perr_clr");
    hold(1'b1, 4);
    ack();

    // stop bit low, line held low 40 cycles from stop start
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, bm);
    chk_lat("ferr.lat", lat, 168);
    check_outs("ferr");
    hold(1'b0, 24);
    chk("ferr.busy_low", bus.busy, 1'b1);
    ack();
    hold(1'b1, 6);
    chk("ferr.busy_high", bus.busy, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    chk_lat("ferr_next.lat", lat, 168);
    check_outs("ferr_next");
    hold(1'b1, 4);
    ack();

    // random formats and bytes
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom);
      d8   = 1'($urandom);
      odd  = 1'($urandom);
      two  = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      send_frame(b, d8, odd, two, flip, 1'b1, lat, bm);
      chk_lat($sformatf("rnd%0d.lat", k), lat, frame_t(d8, two));
      check_outs($sformatf("rnd%0d", k));
      hold(1'b1, 4);
      ack();
    end

    // overrun
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    hold(1'b1, 4);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    check_outs("ovr");
    hold(1'b1, 4);
    ack();
    check_outs("ovr_ack");

    // reset mid-DATA with a valid byte pending
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    hold(1'b1, 4);
    check_outs("pre_rst");
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 10);
    reset = 1'b0;
    #1;
    m_data = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    check_outs("rst");
    chk("rst.busy", bus.busy, 1'b0);
    step();
    bus.rx = 1'b1;
    step();
    reset = 1'b1;
    hold(1'b1, 200);
    check_outs("rst_drop");
    chk("rst_drop.busy", bus.busy, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat, bm);
    chk_lat("post_rst.lat", lat, 168);
    check_outs("post_rst");
    hold(1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the `Tx` transmitter: it samples the line driven by `Tx`, recovers start, 7/8 data bits (LSB first), one parity bit and 1/2 stop bits, and presents the byte with error flags to the host side. It runs on a 16× oversampled receive clock. It uses the same frame-format controls as `Tx` (`d_num`, `parity`, `stop_bits`), so a loopback `Tx`→`uart_rx` pair with identical settings is error-free.

## Interface
- `OVERSAMPLE`, default 16: `clk_rx` cycles per bit; even, ≥ 4.
- `clk_rx` in 1: receive clock, OVERSAMPLE × baud.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `rx` in 1: serial line, idle high, asynchronous to `clk_rx`.
- `d_num` in 1: 0 = 7 data bits, 1 = 8 data bits.
- `parity` in 1: 0 = even (bit = XOR of data), 1 = odd (bit = XOR of data ^ 1).
- `stop_bits` in 1: 0 = one stop bit, 1 = two.
- `rd_ack` in 1: host consumed `data`; clears `rx_valid`.
- `data` out 8: last received byte; bit 7 = 0 in 7-bit mode.
- `rx_valid` out 1: sticky; set on frame completion, cleared by `rd_ack`.
- `parity_err` out 1: parity mismatch for the frame in `data`.
- `frame_err` out 1: a stop bit sampled 0 for the frame in `data`.
- `overrun` out 1: frame completed while `rx_valid` was already 1; sticky until `rd_ack`.
- `busy` out 1: high from start detect until return to IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer, giving `rx_s`. A falling edge on `rx_s` in IDLE is a start detect at cycle t0.
- States: IDLE → START → DATA → PARITY → STOP1 → (STOP2 if `stop_bits`) → IDLE; also WAIT_HIGH.
- `d_num`, `parity` and `stop_bits` are latched at t0. Changes mid-frame are ignored.
- START: sample `rx_s` at t0+OVERSAMPLE/2−1.
  - If high: false start, back to IDLE, no flags changed.
  - If low: continue.
- Each later bit is sampled OVERSAMPLE cycles after the previous sample. Data bits shift in LSB first, N = 7 or 8.
- PARITY: expected bit = XOR(received data bits) ^ latched `parity`. `parity_err` = sampled bit ≠ expected.
- STOP1/STOP2: any stop sample = 0 sets `frame_err`. After the final stop sample:
  - `data`, `parity_err` and `frame_err` update together.
  - `rx_valid` is set.
  - If `rx_valid` was already 1 and `rd_ack` is not high that cycle, `overrun` is set.
  - The new frame always overwrites `data`.
- After the final stop:
  - If `frame_err` was set, go to WAIT_HIGH. The FSM does not re-arm until `rx_s` = 1 (break handling).
  - Otherwise return to IDLE. A start edge is accepted from the next cycle.
- `rd_ack` clears `rx_valid` and `overrun` on the next edge.
  - If `rd_ack` coincides with frame completion, completion wins: `rx_valid` = 1 and `overrun` = 0.
- Reset (any time, including mid-frame) forces all outputs to 0, the FSM to IDLE and the synchronizer to 1. A partial frame is discarded.

## Timing
- Reset values: `data` = 0x00, `rx_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
- `busy` rises at t0+1.
- Sample points, with H = OVERSAMPLE/2−1:
  - data bit i (i = 0..N−1): t0 + H + OVERSAMPLE·(i+1)
  - parity: t0 + H + OVERSAMPLE·(N+1)
  - stop k (k = 1..S): t0 + H + OVERSAMPLE·(N+1+k)
- `rx_valid` and the updated `data`/flags appear at the edge after the last stop sample:
  - 8N1 at OVERSAMPLE = 16: t0+168
  - 8N2: t0+184
  - 7N1: t0+152
- `busy` falls in the same cycle that `rx_valid` rises, unless the FSM enters WAIT_HIGH.
- Pin-to-t0 latency is 2–3 cycles (synchronizer plus edge detect).

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH)
  - `OVERSAMPLE` default
  - frame-format encodings for `d_num`, `parity` and `stop_bits`, also used by `Tx`
- One sub-module, `uart_rx_sync`: 2-FF synchronizer, reset to 1, with a registered falling-edge pulse output.
- Main block contents: bit-period counter, bit index counter, shift register, parity accumulator, FSM, and the output/handshake registers.

## Test plan
- 8-bit, even, 1 stop, byte 0xA5 (parity bit 0), no ack: `data` = 0xA5, `rx_valid` = 1 at t0+168, all error flags 0, `busy` 0 after.
- 7-bit, odd, 2 stops, byte 0x55 with 4 ones (parity bit 1): `data` = 0x55 at t0+168; bit 7 = 0; no errors.
- `rx` low pulse of 5 cycles, then high: no `rx_valid`; `busy` returns to 0 by t0+9; flags unchanged.
- 8-bit even, 0xA5 with parity bit forced to 1: `parity_err` = 1, `data` = 0xA5. Next clean frame clears `parity_err`.
- 0x3C with stop forced 0 and line held low for 40 cycles: `frame_err` = 1; no new start until the line goes high; the next frame is received correctly.
- Two frames 0x11 then 0x22 without `rd_ack`: `data` = 0x22, `overrun` = 1. `rd_ack` clears `rx_valid` and `overrun`. Reset asserted mid-DATA: all outputs 0 and the frame is dropped.
